// File: rtl/dip_debounce.sv
// dip_debounce: synchronises and debounces 64 raw active-low DIP switch lines
// (8 groups of 8) and presents clean, still active-low groups to the slave.
//
// Optional build macro: DIP_DEBOUNCE_IRQ_EN
//   defined   -> sticky irq raised when any group accepts a new value,
//                cleared by irq_ack (a new change in the same cycle wins)
//   undefined -> irq tied low, irq_ack ignored, no interrupt logic built
//
// Ports:
//   clk                      system clock
//   sys_rstn                 asynchronous active-low reset
//   dip_raw0..dip_raw7       raw switch groups, active-low, asynchronous to clk
//   dip_switch0..dip_switch7 debounced groups, active-low, registered
//   irq                      sticky "some group changed" request
//   irq_ack                  single-cycle clear of irq
module dip_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input  logic       clk,
   input  logic       sys_rstn,
   input  logic [7:0] dip_raw0,
   input  logic [7:0] dip_raw1,
   input  logic [7:0] dip_raw2,
   input  logic [7:0] dip_raw3,
   input  logic [7:0] dip_raw4,
   input  logic [7:0] dip_raw5,
   input  logic [7:0] dip_raw6,
   input  logic [7:0] dip_raw7,
   output logic [7:0] dip_switch0,
   output logic [7:0] dip_switch1,
   output logic [7:0] dip_switch2,
   output logic [7:0] dip_switch3,
   output logic [7:0] dip_switch4,
   output logic [7:0] dip_switch5,
   output logic [7:0] dip_switch6,
   output logic [7:0] dip_switch7,
   output logic       irq,
   input  logic       irq_ack
);

   localparam int unsigned NG = 8;
   localparam int unsigned GW = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [GW-1:0] raw_a    [NG];
   logic [GW-1:0] stable_a [NG];
   logic [NG-1:0] chg;

   assign raw_a[0] = dip_raw0;
   assign raw_a[1] = dip_raw1;
   assign raw_a[2] = dip_raw2;
   assign raw_a[3] = dip_raw3;
   assign raw_a[4] = dip_raw4;
   assign raw_a[5] = dip_raw5;
   assign raw_a[6] = dip_raw6;
   assign raw_a[7] = dip_raw7;

   // Outputs are the stable registers themselves.
   assign dip_switch0 = stable_a[0];
   assign dip_switch1 = stable_a[1];
   assign dip_switch2 = stable_a[2];
   assign dip_switch3 = stable_a[3];
   assign dip_switch4 = stable_a[4];
   assign dip_switch5 = stable_a[5];
   assign dip_switch6 = stable_a[6];
   assign dip_switch7 = stable_a[7];

   genvar g;
   for (g = 0; g < NG; g++) begin : g_grp
      logic [GW-1:0]    s1;
      logic [GW-1:0]    s2;
      logic [GW-1:0]    s2_d;
      logic [GW-1:0]    stable;
      logic [CNT_W-1:0] cnt;
      logic             take;
      logic             chg_q;

      // Per-group synchroniser, bounce detector and stability counter.
      // A completed count arms 'take'; the group is loaded one edge later
      // only if s2 is still unchanged, so any late bounce discards it.
      always_ff @(posedge clk or negedge sys_rstn) begin
         if (!sys_rstn) begin
            s1     <= '1;
            s2     <= '1;
            s2_d   <= '1;
            stable <= '1;
            cnt    <= '0;
            take   <= 1'b0;
            chg_q  <= 1'b0;
         end else begin
            s1    <= raw_a[g];
            s2    <= s1;
            s2_d  <= s2;
            take  <= 1'b0;
            chg_q <= 1'b0;
            if (s2 == stable) begin
               cnt <= '0;
            end else if (s2 != s2_d) begin
               cnt <= '0;
            end else if (take) begin
               stable <= s2;
               chg_q  <= 1'b1;
               cnt    <= '0;
            end else if (cnt == CNT_LAST) begin
               take <= 1'b1;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign stable_a[g] = stable;
      assign chg[g]      = chg_q;
   end

`ifdef DIP_DEBOUNCE_IRQ_EN
   // Sticky request; a change pulse takes priority over a coincident ack.
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         irq <= 1'b0;
      end else if (|chg) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`else
   logic       unused_ack;
   logic [NG-1:0] unused_chg;
   assign unused_ack = irq_ack;
   assign unused_chg = chg;
   assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_dip_debounce.sv
// Self-checking bench for dip_debounce (DEBOUNCE_CYCLES=4). A window-based
// reference model predicts each group: a group takes value v at edge e when
// the raw samples taken at edges e-D-3 .. e-2 all equal v and v differs from
// the current output.
module tb_dip_debounce;

   localparam int unsigned D = 4;
   localparam int unsigned H = D + 4;

   logic       clk = 1'b0;
   logic       sys_rstn = 1'b0;
   logic       irq_ack = 1'b0;
   logic       irq;
   logic [7:0] raw [8];
   logic [7:0] sw  [8];

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic [7:0] hist    [8][H];
   logic [7:0] exp_sw  [8];
   logic [7:0] exp_chg;
   logic       exp_irq;

   always #5 clk = ~clk;

   dip_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clk(clk), .sys_rstn(sys_rstn),
      .dip_raw0(raw[0]), .dip_raw1(raw[1]), .dip_raw2(raw[2]), .dip_raw3(raw[3]),
      .dip_raw4(raw[4]), .dip_raw5(raw[5]), .dip_raw6(raw[6]), .dip_raw7(raw[7]),
      .dip_switch0(sw[0]), .dip_switch1(sw[1]), .dip_switch2(sw[2]), .dip_switch3(sw[3]),
      .dip_switch4(sw[4]), .dip_switch5(sw[5]), .dip_switch6(sw[6]), .dip_switch7(sw[7]),
      .irq(irq), .irq_ack(irq_ack)
   );

   // Reference model
   always @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < H; i++) hist[g][i] = 8'hFF;
            exp_sw[g] = 8'hFF;
         end
         exp_chg = 8'h00;
         exp_irq = 1'b0;
      end else begin
         logic [7:0] chg_now;
         logic [7:0] v;
         logic       same;
`ifdef DIP_DEBOUNCE_IRQ_EN
         if (exp_chg != 8'h00) exp_irq = 1'b1;
         else if (irq_ack)     exp_irq = 1'b0;
`else
         exp_irq = 1'b0;
`endif
         chg_now = 8'h00;
         for (int g = 0; g < 8; g++) begin
            for (int i = H - 1; i > 0; i--) hist[g][i] = hist[g][i-1];
            hist[g][0] = raw[g];
            v = hist[g][2];
            same = 1'b1;
            for (int i = 2; i < H; i++) if (hist[g][i] != v) same = 1'b0;
            if (same && v != exp_sw[g]) begin
               exp_sw[g]  = v;
               chg_now[g] = 1'b1;
            end
         end
         exp_chg = chg_now;
      end
   end

   task automatic test_reset();
      for (int g = 0; g < 8; g++) raw[g] = 8'hFF;
      raw[0]   = 8'h00;
      irq_ack  = 1'b0;
      sys_rstn = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 8; g++) begin
         n_total++;
         if (sw[g] !== 8'hFF) $display("FAIL reset_sw%0d got %h want ff", g, sw[g]);
         else n_pass++;
      end
      n_total++;
      if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq);
      else n_pass++;
      @(posedge clk);
      #2 sys_rstn = 1'b1;
      #1;
      for (int g = 0; g < 8; g++) begin
         n_total++;
         if (sw[g] !== 8'hFF) $display("FAIL release_sw%0d got %h want ff", g, sw[g]);
         else n_pass++;
      end
      @(negedge clk);
      raw[0] = 8'hFF;
      repeat (10) begin
         @(negedge clk);
         for (int g = 0; g < 8; g++) begin
            n_total++;
            if (sw[g] !== exp_sw[g]) $display("FAIL post_reset_sw%0d got %h want %h", g, sw[g], exp_sw[g]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_clean_change();
      @(negedge clk);
      raw[3] = 8'h5A;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_total++;
         if (sw[3] !== ((k < 7) ? 8'hFF : 8'h5A))
            $display("FAIL clean_sw3_edge%0d got %h want %h", k, sw[3], (k < 7) ? 8'hFF : 8'h5A);
         else n_pass++;
         for (int g = 0; g < 8; g++) begin
            n_total++;
            if (sw[g] !== exp_sw[g]) $display("FAIL clean_sw%0d got %h want %h", g, sw[g], exp_sw[g]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_bounce();
      int n_chg;
      int chg_edge;
      logic [7:0] prev;
      n_chg = 0;
      chg_edge = -1;
      prev = sw[0];
      for (int i = 0; i < 20; i++) begin
         raw[0] = (((i / 2) % 2) == 0) ? 8'hFE : 8'hFF;
         @(negedge clk);
         if (sw[0] !== prev) n_chg++;
         prev = sw[0];
      end
      raw[0] = 8'hFE;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (sw[0] !== prev) begin
            n_chg++;
            chg_edge = k;
         end
         prev = sw[0];
         n_total++;
         if (sw[0] !== exp_sw[0]) $display("FAIL bounce_model got %h want %h", sw[0], exp_sw[0]);
         else n_pass++;
      end
      n_total++;
      if (n_chg != 1) $display("FAIL bounce_changes got %0d want 1", n_chg);
      else n_pass++;
      n_total++;
      if (chg_edge != 7) $display("FAIL bounce_edge got %0d want 7", chg_edge);
      else n_pass++;
      n_total++;
      if (sw[0] !== 8'hFE) $display("FAIL bounce_final got %h want fe", sw[0]);
      else n_pass++;
   endtask

   task automatic test_short_glitch();
      @(negedge clk) irq_ack = 1'b1;
      @(negedge clk) irq_ack = 1'b0;
      raw[7] = 8'h00;
      repeat (3) @(negedge clk);
      raw[7] = 8'hFF;
      repeat (12) begin
         @(negedge clk);
         n_total++;
         if (sw[7] !== 8'hFF) $display("FAIL glitch_sw7 got %h want ff", sw[7]);
         else n_pass++;
         n_total++;
         if (irq !== 1'b0) $display("FAIL glitch_irq got %b want 0", irq);
         else n_pass++;
      end
   endtask

   task automatic test_irq();
      int rises;
      logic prev;
      rises = 0;
      prev = irq;
      @(negedge clk);
      raw[1] = 8'h33;
      raw[2] = 8'hC3;
      repeat (14) begin
         @(negedge clk);
         if (irq && !prev) rises++;
         prev = irq;
         n_total++;
         if (irq !== exp_irq) $display("FAIL irq_model got %b want %b", irq, exp_irq);
         else n_pass++;
      end
      n_total++;
`ifdef DIP_DEBOUNCE_IRQ_EN
      if (rises != 1) $display("FAIL irq_single got %0d want 1", rises);
      else n_pass++;
`else
      if (rises != 0) $display("FAIL irq_tied got %0d want 0", rises);
      else n_pass++;
`endif
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_ack_clear got %b want 0", irq);
      else n_pass++;
      raw[4] = 8'h81;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         irq_ack = (k == 7 || k == 8);
         if (k == 8) begin
            n_total++;
`ifdef DIP_DEBOUNCE_IRQ_EN
            if (irq !== 1'b1) $display("FAIL irq_set_wins got %b want 1", irq);
`else
            if (irq !== 1'b0) $display("FAIL irq_set_wins got %b want 0", irq);
`endif
            else n_pass++;
         end
         n_total++;
         if (irq !== exp_irq) $display("FAIL irq_seq_model got %b want %b", irq, exp_irq);
         else n_pass++;
      end
      irq_ack = 1'b0;
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_final_clear got %b want 0", irq);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      raw[5] = 8'h0F;
      repeat (4) @(negedge clk);
      #2 sys_rstn = 1'b0;
      #1;
      for (int g = 0; g < 8; g++) begin
         n_total++;
         if (sw[g] !== 8'hFF) $display("FAIL midrst_sw%0d got %h want ff", g, sw[g]);
         else n_pass++;
      end
      n_total++;
      if (irq !== 1'b0) $display("FAIL midrst_irq got %b want 0", irq);
      else n_pass++;
      repeat (2) @(negedge clk);
      sys_rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_total++;
         if (sw[5] !== ((k < 7) ? 8'hFF : 8'h0F))
            $display("FAIL midrst_sw5_edge%0d got %h want %h", k, sw[5], (k < 7) ? 8'hFF : 8'h0F);
         else n_pass++;
         for (int g = 0; g < 8; g++) begin
            n_total++;
            if (sw[g] !== exp_sw[g]) $display("FAIL midrst_sw%0d got %h want %h", g, sw[g], exp_sw[g]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int g = 0; g < 8; g++) begin
            if ($urandom_range(0, 9) == 0) raw[g] = 8'($urandom);
         end
         irq_ack = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         for (int g = 0; g < 8; g++) begin
            n_total++;
            if (sw[g] !== exp_sw[g]) $display("FAIL rand_sw%0d cyc%0d got %h want %h", g, c, sw[g], exp_sw[g]);
            else n_pass++;
         end
         n_total++;
         if (irq !== exp_irq) $display("FAIL rand_irq cyc%0d got %b want %b", c, irq, exp_irq);
         else n_pass++;
      end
      irq_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_change();
      test_bounce();
      test_short_glitch();
      test_irq();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
